// File: rtl/aes_sub_shift_axi_if.sv
// AXI4-Lite slave bus bundle for the AES SubBytes/ShiftRows peripheral.
interface aes_sub_shift_axi_if #(
  parameter int unsigned AddrWidth = 6,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]   S_AXI_AWADDR;
  logic [2:0]             S_AXI_AWPROT;
  logic                   S_AXI_AWVALID;
  logic                   S_AXI_AWREADY;
  logic [DataWidth-1:0]   S_AXI_WDATA;
  logic [DataWidth/8-1:0] S_AXI_WSTRB;
  logic                   S_AXI_WVALID;
  logic                   S_AXI_WREADY;
  logic [1:0]             S_AXI_BRESP;
  logic                   S_AXI_BVALID;
  logic                   S_AXI_BREADY;
  logic [AddrWidth-1:0]   S_AXI_ARADDR;
  logic [2:0]             S_AXI_ARPROT;
  logic                   S_AXI_ARVALID;
  logic                   S_AXI_ARREADY;
  logic [DataWidth-1:0]   S_AXI_RDATA;
  logic [1:0]             S_AXI_RRESP;
  logic                   S_AXI_RVALID;
  logic                   S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/aes_sub_shift_axi.sv
// AXI4-Lite peripheral: AES SubBytes+ShiftRows (encrypt) or InvShiftRows+InvSubBytes (decrypt)
// on one 128-bit state, one column of S-boxes per cycle.
module aes_sub_shift_axi #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  aes_sub_shift_axi_if.slave     s_axi,
  output logic                   done_pulse
);

  typedef enum logic [1:0] {StIdle, StSub, StPerm} state_e;
  // Element k is column k; bits [31:24] row0 ... [7:0] row3.
  typedef logic [3:0][31:0] block_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] aes_inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_col(input logic [31:0] col, input logic inv);
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = inv ? aes_inv_sbox(col[8*r +: 8]) : aes_sbox(col[8*r +: 8]);
    end
    return res;
  endfunction

  // Row r rotates left by r columns (encrypt) or right by r (decrypt).
  function automatic block_t shift_rows(input block_t b, input logic inv);
    block_t     res;
    logic [1:0] src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? 2'(c + 4 - r) : 2'(c + r);
        res[c][31-8*r -: 8] = b[src][31-8*r -: 8];
      end
    end
    return res;
  endfunction

  logic [C_S_AXI_ADDR_WIDTH-1:0] waddr, raddr;
  logic [3:0]                    widx, ridx;
  logic                          wr_en, rd_en, start_req, start;

  logic                          wready_q, bvalid_q, arready_q, rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_mux;

  block_t     in_q;
  logic       ctrl_inv_q;
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  block_t     work_q, work_d;
  block_t     out_q, out_d;
  logic       op_inv_q, op_inv_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       done_pulse_q, done_pulse_d;

  assign waddr = s_axi.S_AXI_AWADDR;
  assign raddr = s_axi.S_AXI_ARADDR;
  assign widx  = waddr[5:2];
  assign ridx  = raddr[5:2];

  // Ready is only raised while both valids are held, so ready & valid marks the handshake.
  assign wr_en     = wready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_en     = arready_q & s_axi.S_AXI_ARVALID;
  assign start_req = wr_en && (widx == 4'd4) && s_axi.S_AXI_WSTRB[0] && s_axi.S_AXI_WDATA[0];
  assign start     = start_req && (state_q == StIdle);

  assign s_axi.S_AXI_AWREADY = wready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign done_pulse          = done_pulse_q;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, waddr[1:0], raddr[1:0]};

  // AXI handshake state: single outstanding write and read.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wready_q  <= s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~wready_q;
      arready_q <= s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
      end else if (s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_mux;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Software-writable registers: IN words with byte strobes, CTRL.INV.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      in_q       <= '0;
      ctrl_inv_q <= 1'b0;
    end else if (wr_en) begin
      if (widx < 4'd4) begin
        for (int b = 0; b < 4; b++) begin
          if (s_axi.S_AXI_WSTRB[b]) in_q[widx[1:0]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
        end
      end else if (widx == 4'd4 && s_axi.S_AXI_WSTRB[0]) begin
        ctrl_inv_q <= s_axi.S_AXI_WDATA[1];
      end
    end
  end

  // Read data decode; START reads back as 0.
  always_comb begin
    rdata_mux = '0;
    case (ridx)
      4'd0, 4'd1, 4'd2, 4'd3: rdata_mux = in_q[ridx[1:0]];
      4'd4:    rdata_mux = {30'd0, ctrl_inv_q, 1'b0};
      4'd5:    rdata_mux = {30'd0, done_q, busy_q};
      4'd6:    rdata_mux = out_q[0];
      4'd7:    rdata_mux = out_q[1];
      4'd8:    rdata_mux = out_q[2];
      4'd9:    rdata_mux = out_q[3];
      default: rdata_mux = '0;
    endcase
  end

  // Core state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      work_q       <= '0;
      out_q        <= '0;
      op_inv_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      out_q        <= out_d;
      op_inv_q     <= op_inv_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  // Core next state: encrypt runs SUB x4 then PERM; decrypt runs PERM then SUB x4.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    work_d       = work_q;
    out_d        = out_q;
    op_inv_d     = op_inv_q;
    busy_d       = busy_q;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          work_d   = in_q;
          op_inv_d = s_axi.S_AXI_WDATA[1];
          done_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = s_axi.S_AXI_WDATA[1] ? StPerm : StSub;
        end
      end
      StSub: begin
        work_d[cnt_q] = sub_col(work_q[cnt_q], op_inv_q);
        cnt_d         = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (op_inv_q) begin
            out_d        = work_d;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
            state_d      = StIdle;
          end else begin
            state_d = StPerm;
          end
        end
      end
      StPerm: begin
        if (op_inv_q) begin
          work_d  = shift_rows(work_q, 1'b1);
          cnt_d   = '0;
          state_d = StSub;
        end else begin
          out_d        = shift_rows(work_q, 1'b0);
          busy_d       = 1'b0;
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_aes_sub_shift_axi.sv
// Bench for aes_sub_shift_axi: known-answer vectors plus AXI and timing corner sequences.
module tb_aes_sub_shift_axi;

  logic clk = 1'b0;
  logic rst_n;
  logic done_pulse;
  always #5 clk = ~clk;

  aes_sub_shift_axi_if axi ();

  aes_sub_shift_axi dut (
    .ACLK       (clk),
    .ARESETN    (rst_n),
    .s_axi      (axi),
    .done_pulse (done_pulse)
  );

  typedef struct {
    string       name;
    logic [31:0] din[4];
    logic        inv;
    logic [31:0] dout[4];
  } vec_t;

  vec_t        vecs[6];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          hs_cyc = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_pulse === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit ok;
    @(posedge clk) #1;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.S_AXI_AWREADY && axi.S_AXI_WREADY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("aw_w_ready");
    hs_cyc = cyc + 1;
    @(posedge clk) #1;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (axi.S_AXI_BVALID) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("bvalid");
    else check("bresp", {30'd0, axi.S_AXI_BRESP}, 32'd0);
    @(posedge clk) #1;
    axi.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] addr, input int hold, input logic [31:0] hold_exp,
                          output logic [31:0] data);
    bit ok;
    @(posedge clk) #1;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.S_AXI_ARREADY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("arready");
    @(posedge clk) #1;
    axi.S_AXI_ARVALID = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (axi.S_AXI_RVALID) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("rvalid");
    else check("rresp", {30'd0, axi.S_AXI_RRESP}, 32'd0);
    data = axi.S_AXI_RDATA;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("rvalid_held", {31'd0, axi.S_AXI_RVALID}, 32'd1);
      check("rdata_stable", axi.S_AXI_RDATA, hold_exp);
    end
    axi.S_AXI_RREADY = 1'b1;
    @(posedge clk) #1;
    axi.S_AXI_RREADY = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, 0, 32'd0, d);
    check(name, d, exp);
  endtask

  // Pops one expected word per OUT register from the scoreboard.
  task automatic check_out(input string name);
    logic [31:0] d;
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      axi_read(6'(8'h18 + 4 * k), 0, 32'd0, d);
      if (exp_q.size() == 0) begin
        timeout({name, "_scoreboard_empty"});
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_out%0d", name, k), d, e);
      end
    end
  endtask

  task automatic wait_done(input string name, input int start_hs, input int base);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt > base) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout({name, "_done"});
    else check({name, "_latency"}, 32'(last_done_cyc - start_hs), 32'd5);
  endtask

  task automatic push_exp(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3);
    exp_q.push_back(w0);
    exp_q.push_back(w1);
    exp_q.push_back(w2);
    exp_q.push_back(w3);
  endtask

  task automatic run_vec(input vec_t v);
    int st, base;
    for (int k = 0; k < 4; k++) axi_write(6'(4 * k), v.din[k], 4'hf);
    base = done_cnt;
    axi_write(6'h10, v.inv ? 32'h3 : 32'h1, 4'h1);
    st = hs_cyc;
    push_exp(v.dout[0], v.dout[1], v.dout[2], v.dout[3]);
    read_check({v.name, "_status_busy"}, 6'h14, 32'h1);
    wait_done(v.name, st, base);
    read_check({v.name, "_status_done"}, 6'h14, 32'h2);
    read_check({v.name, "_ctrl"}, 6'h10, v.inv ? 32'h2 : 32'h0);
    check_out(v.name);
  endtask

  initial begin
    int          st, base;
    logic [31:0] d;
    bit          ok;

    vecs[0].name = "enc_r1";
    vecs[0].din  = '{32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808};
    vecs[0].inv  = 1'b0;
    vecs[0].dout = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    vecs[1].name = "dec_r1";
    vecs[1].din  = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    vecs[1].inv  = 1'b1;
    vecs[1].dout = '{32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808};
    vecs[2].name = "enc_r2";
    vecs[2].din  = '{32'ha49c7ff2, 32'h689f352b, 32'h6b5bea43, 32'h026a5049};
    vecs[2].inv  = 1'b0;
    vecs[2].dout = '{32'h49db873b, 32'h45395389, 32'h7f02d2f1, 32'h77de961a};
    vecs[3].name = "dec_r2";
    vecs[3].din  = '{32'h49db873b, 32'h45395389, 32'h7f02d2f1, 32'h77de961a};
    vecs[3].inv  = 1'b1;
    vecs[3].dout = '{32'ha49c7ff2, 32'h689f352b, 32'h6b5bea43, 32'h026a5049};
    vecs[4].name = "enc_zero";
    vecs[4].din  = '{32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4].inv  = 1'b0;
    vecs[4].dout = '{32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363};
    vecs[5].name = "dec_63";
    vecs[5].din  = '{32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363};
    vecs[5].inv  = 1'b1;
    vecs[5].dout = '{32'h0, 32'h0, 32'h0, 32'h0};

    rst_n = 1'b0;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    check("rst_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("rst_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd0);
    check("rst_rdata", axi.S_AXI_RDATA, 32'd0);
    check("rst_done_pulse", {31'd0, done_pulse}, 32'd0);
    rst_n = 1'b1;
    read_check("rst_status", 6'h14, 32'h0);
    read_check("rst_ctrl", 6'h10, 32'h0);
    read_check("rst_in0", 6'h00, 32'h0);
    push_exp(32'h0, 32'h0, 32'h0, 32'h0);
    check_out("rst");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // IN write during BUSY is stored but does not disturb the running operation.
    for (int k = 0; k < 4; k++) axi_write(6'(4 * k), vecs[0].din[k], 4'hf);
    base = done_cnt;
    axi_write(6'h10, 32'h1, 4'h1);
    st = hs_cyc;
    push_exp(vecs[0].dout[0], vecs[0].dout[1], vecs[0].dout[2], vecs[0].dout[3]);
    axi_write(6'h00, 32'hffffffff, 4'hf);
    wait_done("busy_in", st, base);
    repeat (10) @(negedge clk);
    check("busy_in_pulses", 32'(done_cnt - base), 32'd1);
    read_check("busy_in_in0", 6'h00, 32'hffffffff);
    check_out("busy_in");

    // START during BUSY is ignored, but its INV bit lands in CTRL.
    axi_write(6'h00, vecs[0].din[0], 4'hf);
    base = done_cnt;
    axi_write(6'h10, 32'h1, 4'h1);
    st = hs_cyc;
    push_exp(vecs[0].dout[0], vecs[0].dout[1], vecs[0].dout[2], vecs[0].dout[3]);
    axi_write(6'h10, 32'h3, 4'h1);
    wait_done("busy_start", st, base);
    repeat (10) @(negedge clk);
    check("busy_start_pulses", 32'(done_cnt - base), 32'd1);
    read_check("busy_start_ctrl", 6'h10, 32'h2);
    check_out("busy_start");

    // RDATA held while RREADY is low.
    axi_read(6'h18, 6, vecs[0].dout[0], d);
    check("rhold_first", d, vecs[0].dout[0]);

    // Byte strobes, unmapped and read-only writes.
    axi_write(6'h04, 32'h11223344, 4'hf);
    axi_write(6'h04, 32'haabbccdd, 4'h1);
    read_check("wstrb_in1", 6'h04, 32'h112233dd);
    axi_write(6'h30, 32'hdeadbeef, 4'hf);
    read_check("unmapped_rd", 6'h30, 32'h0);
    axi_write(6'h14, 32'hffffffff, 4'hf);
    read_check("status_ro", 6'h14, 32'h2);

    // BREADY held low: BVALID stays up and the next write is stalled.
    @(posedge clk) #1;
    axi.S_AXI_AWADDR = 6'h08; axi.S_AXI_WDATA = 32'h01020304; axi.S_AXI_WSTRB = 4'hf;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1; axi.S_AXI_BREADY = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.S_AXI_AWREADY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("bstall_first");
    @(posedge clk) #1;
    axi.S_AXI_AWADDR = 6'h0c; axi.S_AXI_WDATA = 32'h05060708;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bstall_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd1);
      check("bstall_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    end
    @(posedge clk) #1;
    axi.S_AXI_BREADY = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi.S_AXI_AWREADY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("bstall_second");
    @(posedge clk) #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    repeat (2) @(posedge clk);
    #1 axi.S_AXI_BREADY = 1'b0;
    read_check("bstall_in2", 6'h08, 32'h01020304);
    read_check("bstall_in3", 6'h0c, 32'h05060708);

    // Reset during SUB aborts the operation.
    base = done_cnt;
    axi_write(6'h10, 32'h1, 4'h1);
    @(posedge clk) #1;
    rst_n = 1'b0;
    #1;
    check("abort_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd0);
    check("abort_wready", {31'd0, axi.S_AXI_WREADY}, 32'd0);
    check("abort_bvalid", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    check("abort_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
    check("abort_rvalid", {31'd0, axi.S_AXI_RVALID}, 32'd0);
    check("abort_rdata", axi.S_AXI_RDATA, 32'd0);
    check("abort_resp", {28'd0, axi.S_AXI_BRESP, axi.S_AXI_RRESP}, 32'd0);
    check("abort_done_pulse", {31'd0, done_pulse}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_pulse", 32'(done_cnt - base), 32'd0);
    read_check("abort_status", 6'h14, 32'h0);
    read_check("abort_in0", 6'h00, 32'h0);
    push_exp(32'h0, 32'h0, 32'h0, 32'h0);
    check_out("abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_sub_shift_axi.md
Name: aes_sub_shift_axi

Overview:
- AXI4-Lite slave peripheral that applies AES SubBytes followed by ShiftRows (encrypt mode), or InvShiftRows followed by InvSubBytes (decrypt mode), to one 128-bit state.
- Sits directly upstream of the MixColumns/InvMixColumns peripheral in the AES round datapath.
- Software writes four state words, starts the operation, polls for done, then reads four result words and forwards them to the mix stage.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 6, byte-address width; covers the 0x00–0x24 register map.

Ports:
- ACLK  in  1  single clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  6  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte write enables.
- S_AXI_WVALID  in  1; S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2  always OKAY (2'b00).
- S_AXI_BVALID  out  1; S_AXI_BREADY  in  1  write-response handshake.
- S_AXI_ARADDR  in  6  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always OKAY.
- S_AXI_RVALID  out  1; S_AXI_RREADY  in  1  read-data handshake.
- done_pulse  out  1  one-cycle pulse when a result is written.

Behaviour:
- Register map (word-aligned; ADDR[1:0] ignored):
  - 0x00–0x0C: IN0..IN3, read/write.
  - 0x10: CTRL. bit0 START, write-1 self-clearing, always reads 0. bit1 INV, read/write.
  - 0x14: STATUS, read-only. bit0 BUSY, bit1 DONE.
  - 0x18–0x24: OUT0..OUT3, read-only.
  - Unmapped addresses: reads return 0; writes are dropped; response is OKAY.
- State layout: word k is column k. bits[31:24]=row0, [23:16]=row1, [15:8]=row2, [7:0]=row3.
- Write channel:
  - AWREADY and WREADY assert together for one cycle when AWVALID and WVALID are both high, BVALID is low, and no ready is already asserted.
  - Register update honours WSTRB per byte.
  - BVALID asserts the cycle after the handshake and holds until BREADY.
  - Only one write is outstanding.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RDATA is registered; RVALID asserts the next cycle and holds until RREADY. RDATA is stable while RVALID is high.
- Core FSM states: IDLE, SUB, PERM.
  - IDLE: a write with START=1 (WSTRB[0] set) latches IN0..IN3 into a working state and latches INV, clears DONE, sets BUSY, clears the column counter, and moves to SUB.
  - Encrypt mode: SUB (4 cycles) passes column[cnt] through 4 aes_sbox instances, one column per cycle, cnt 0→3. PERM (1 cycle) applies ShiftRows: row r rotates left by r columns. The result goes to OUT0..OUT3.
  - Decrypt mode: the permutation (InvShiftRows, row r rotates right by r) is applied to the latched input first. SUB then uses aes_inv_sbox instances. The result is written at the end of the 4th SUB cycle. The block spends 1 cycle in PERM before SUB, so total latency is identical to encrypt mode.
  - Latency: BUSY falls and DONE rises exactly 5 cycles after the START handshake cycle. done_pulse is high in that same cycle.
- Boundary conditions:
  - START written while BUSY: ignored; the INV bit in that write still updates CTRL.
  - IN writes while BUSY: stored, but they do not affect the running operation.
  - OUT registers hold the previous result until PERM/SUB completion overwrites all four words in the same cycle.
  - DONE is sticky until the next accepted START.
- Reset (async assert, sync deassert by the integrator): all READY/VALID outputs 0, RDATA 0, BRESP/RRESP 0, done_pulse 0, FSM IDLE, and all IN, OUT, CTRL and STATUS registers cleared to 0. Reset mid-operation aborts with no result written.

Test Plan:
- Encrypt (FIPS-197 App. B, round 1): write IN=0x193de3be, 0xa0f4e22b, 0x9ac68d2a, 0xe9f84808; write CTRL=0x1; poll STATUS=0x2 -> OUT=0xd4bf5d30, 0xe0b452ae, 0xb84111f1, 0x1e2798e5.
- Decrypt: IN = the encrypt-test outputs, CTRL=0x3 -> OUT=0x193de3be, 0xa0f4e22b, 0x9ac68d2a, 0xe9f84808; CTRL reads 0x2.
- Latency and pulse: STATUS=0x1 on the cycle after START; done_pulse high exactly 5 cycles after the START handshake; STATUS=0x2 afterwards.
- Busy interference: START, then next cycle write IN0=0xffffffff and START again -> result matches the original inputs, only one done_pulse; IN0 reads 0xffffffff.
- AXI corner cases:
  - BREADY held low 10 cycles -> BVALID stays high and the next write is stalled.
  - WSTRB=0x1 to IN1 -> only bits[7:0] change.
  - Read at 0x30 -> 0 with OKAY.
  - RREADY low -> RDATA stable.
- Reset mid-op: deassert ARESETN during SUB -> all outputs 0 immediately, STATUS=0 and OUT=0 after release, no done_pulse.
